// File: rtl/snake_pkg.sv
// snake_pkg
//   Shared constants and types for the snake game blocks.
//   - Game phase encoding (the numeric values appear on game_ctrl.state).
//   - Playfield grid size used by the snake, food and renderer blocks.
//   - Score range.
package snake_pkg;

  // Phase codes as seen on game_ctrl.state.
  localparam logic [2:0] STATE_IDLE = 3'd0;
  localparam logic [2:0] STATE_ARM  = 3'd1;
  localparam logic [2:0] STATE_PLAY = 3'd2;
  localparam logic [2:0] STATE_OVER = 3'd3;
  localparam logic [2:0] STATE_WIN  = 3'd4;

  typedef enum logic [2:0] {
    GS_IDLE = STATE_IDLE,
    GS_ARM  = STATE_ARM,
    GS_PLAY = STATE_PLAY,
    GS_OVER = STATE_OVER,
    GS_WIN  = STATE_WIN
  } game_state_e;

  // Playfield in cells.
  localparam int GRID_W = 32;
  localparam int GRID_H = 24;

  // Score saturates here; the victory flag is raised by collision logic.
  localparam int MAX_SCORE = 15;
  localparam int SCORE_W   = 4;

endpackage

// File: rtl/game_ctrl_move_rate_gen.sv
// move_rate_gen
//   Decides, for the current frame, whether the snake is due to advance.
//   The move period shrinks with score and is clamped at MIN_PERIOD:
//     period = max(MIN_PERIOD, BASE_PERIOD - SPEED_STEP * score)
//   The frame counter itself lives in game_ctrl (it is shared by all phases);
//   this block only does the arithmetic and the compare.
//
// Ports
//   enable     in   1  high while the game is in PLAY
//   frame_tick in   1  one-cycle pulse per video frame
//   score      in   4  live score 0..15
//   count      in   8  frames counted since the last move / PLAY entry
//   move_due   out  1  combinational: this frame completes a move period
module move_rate_gen
  import snake_pkg::*;
#(
  parameter int BASE_PERIOD = 30,
  parameter int SPEED_STEP  = 2,
  parameter int MIN_PERIOD  = 8
) (
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [3:0] score,
  input  logic [7:0] count,
  output logic       move_due
);

  // Arithmetic is done signed and wider than the counter so that a large
  // score times step cannot wrap around into a huge positive period.
  localparam logic signed [11:0] BASE_S = 12'(BASE_PERIOD);
  localparam logic signed [11:0] STEP_S = 12'(SPEED_STEP);
  localparam logic signed [11:0] MIN_S  = 12'(MIN_PERIOD);

  logic signed [11:0] score_s;
  logic signed [11:0] raw_period;
  logic signed [11:0] period;
  logic signed [11:0] count_s;

  always_comb begin
    score_s    = $signed({8'd0, score});
    count_s    = $signed({4'd0, count});
    raw_period = BASE_S - (STEP_S * score_s);
    period     = (raw_period < MIN_S) ? MIN_S : raw_period;
    // ">=" rather than "==": if the score rises while the counter is already
    // past the new, shorter period, the very next frame still yields a move.
    move_due   = enable && frame_tick && (count_s >= (period - 12'sd1));
  end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl
//   Top-level sequencer for the snake game. Runs the game phase FSM
//   (IDLE -> ARM -> PLAY -> OVER/WIN -> ARM ...), paces snake moves from the
//   frame tick, and issues the clear pulse that re-initialises the snake,
//   food and collision/victory blocks at the start of every game.
//
//   All outputs are single-cycle pulses or levels driven from flops; there is
//   no handshake. A pulse is seen by consumers for exactly one clk cycle and
//   is never held or retried.
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high
//   frame_tick in   1  one-cycle pulse per video frame
//   start      in   1  debounced one-cycle start/restart pulse
//   game_over  in   1  collision flag (level)
//   victory    in   1  victory flag (level)
//   score      in   4  current score 0..15
//   state      out  3  phase code IDLE=0 ARM=1 PLAY=2 OVER=3 WIN=4
//   clear_game out  1  one-cycle pulse on every entry into ARM
//   move_tick  out  1  one-cycle pulse: snake advances one cell
//   play_en    out  1  high only in PLAY
//   hold_done  out  1  OVER/WIN hold time has elapsed; start is accepted
module game_ctrl
  import snake_pkg::*;
#(
  parameter int BASE_PERIOD = 30,
  parameter int SPEED_STEP  = 2,
  parameter int MIN_PERIOD  = 8,
  parameter int ARM_FRAMES  = 60,
  parameter int HOLD_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       game_over,
  input  logic       victory,
  input  logic [3:0] score,
  output logic [2:0] state,
  output logic       clear_game,
  output logic       move_tick,
  output logic       play_en,
  output logic       hold_done
);

  localparam logic [7:0] ARM_LAST   = 8'(ARM_FRAMES - 1);
  localparam logic [7:0] HOLD_COUNT = 8'(HOLD_FRAMES);
  // A zero hold means start is accepted as soon as OVER/WIN is entered.
  localparam logic       HOLD_NONE  = (HOLD_FRAMES == 0);

  game_state_e st;
  logic [7:0]  cnt;
  logic [7:0]  cnt_sat;
  logic        play_active;
  logic        move_due;

  // The one frame counter is shared by every phase; it never wraps.
  assign cnt_sat     = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign play_active = (st == GS_PLAY);

  // The register is the phase code; exposing it directly keeps state
  // registered and lets checkers observe the FSM.
  assign state = st;

  move_rate_gen #(
    .BASE_PERIOD (BASE_PERIOD),
    .SPEED_STEP  (SPEED_STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_move_rate_gen (
    .enable     (play_active),
    .frame_tick (frame_tick),
    .score      (score),
    .count      (cnt),
    .move_due   (move_due)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset is shared with the snake/food/collision blocks, so no
      // clear_game is needed here; every pending pulse is dropped.
      st         <= GS_IDLE;
      cnt        <= 8'd0;
      clear_game <= 1'b0;
      move_tick  <= 1'b0;
      play_en    <= 1'b0;
      hold_done  <= 1'b0;
    end else begin
      clear_game <= 1'b0;
      move_tick  <= 1'b0;

      case (st)
        GS_IDLE: begin
          if (start) begin
            st         <= GS_ARM;
            cnt        <= 8'd0;
            clear_game <= 1'b1;
          end else if (frame_tick) begin
            cnt <= cnt_sat;
          end
        end

        // Countdown before the first move. game_over/victory are ignored
        // here because the collision block is still coming out of clear.
        GS_ARM: begin
          if (frame_tick) begin
            if (cnt >= ARM_LAST) begin
              st      <= GS_PLAY;
              cnt     <= 8'd0;
              play_en <= 1'b1;
            end else begin
              cnt <= cnt_sat;
            end
          end
        end

        // Exits are checked before the move so that the snake never moves
        // on the cycle the game ends; game_over outranks victory.
        GS_PLAY: begin
          if (game_over) begin
            st        <= GS_OVER;
            cnt       <= 8'd0;
            play_en   <= 1'b0;
            hold_done <= HOLD_NONE;
          end else if (victory) begin
            st        <= GS_WIN;
            cnt       <= 8'd0;
            play_en   <= 1'b0;
            hold_done <= HOLD_NONE;
          end else if (frame_tick) begin
            if (move_due) begin
              move_tick <= 1'b1;
              cnt       <= 8'd0;
            end else begin
              cnt <= cnt_sat;
            end
          end
        end

        // End screens. start is only honoured once the hold has expired;
        // an early press is simply dropped.
        GS_OVER, GS_WIN: begin
          if (start && hold_done) begin
            st         <= GS_ARM;
            cnt        <= 8'd0;
            clear_game <= 1'b1;
            hold_done  <= 1'b0;
          end else if (frame_tick && (cnt < HOLD_COUNT)) begin
            cnt <= cnt_sat;
            if (cnt_sat == HOLD_COUNT) begin
              hold_done <= 1'b1;
            end
          end
        end

        default: begin
          st        <= GS_IDLE;
          cnt       <= 8'd0;
          play_en   <= 1'b0;
          hold_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl
//   Directed scenarios followed by randomized traffic. A reference model
//   written in terms of "frames since phase entry / since last move" predicts
//   every output after every clock edge; predictions go through an expected
//   queue and are compared one field at a time.
module tb_game_ctrl;

  localparam int BASE_PERIOD = 30;
  localparam int SPEED_STEP  = 2;
  localparam int MIN_PERIOD  = 8;
  localparam int ARM_FRAMES  = 60;
  localparam int HOLD_FRAMES = 90;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset      = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start      = 1'b0;
  logic       game_over  = 1'b0;
  logic       victory    = 1'b0;
  logic [3:0] score      = 4'd0;

  logic [2:0] state;
  logic       clear_game;
  logic       move_tick;
  logic       play_en;
  logic       hold_done;

  game_ctrl #(
    .BASE_PERIOD (BASE_PERIOD),
    .SPEED_STEP  (SPEED_STEP),
    .MIN_PERIOD  (MIN_PERIOD),
    .ARM_FRAMES  (ARM_FRAMES),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .game_over  (game_over),
    .victory    (victory),
    .score      (score),
    .state      (state),
    .clear_game (clear_game),
    .move_tick  (move_tick),
    .play_en    (play_en),
    .hold_done  (hold_done)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] exp_q[$];   // {state, clear_game, move_tick, play_en, hold_done}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases as plain numbers; "frames" counts frame ticks seen in the current
  // phase (PLAY: since the last move).
  int m_phase  = 0;
  int m_frames = 0;
  bit m_hold   = 0;

  function automatic int move_period(input int sc);
    int p;
    p = BASE_PERIOD - SPEED_STEP * sc;
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  task automatic model_step();
    bit clr;
    bit mv;
    clr = 0;
    mv  = 0;
    if (reset) begin
      m_phase  = 0;
      m_frames = 0;
      m_hold   = 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_frames = 0; clr = 1; end
        1: if (frame_tick) begin
             m_frames++;
             if (m_frames == ARM_FRAMES) begin m_phase = 2; m_frames = 0; end
           end
        2: if (game_over) begin
             m_phase = 3; m_frames = 0; m_hold = (HOLD_FRAMES == 0);
           end else if (victory) begin
             m_phase = 4; m_frames = 0; m_hold = (HOLD_FRAMES == 0);
           end else if (frame_tick) begin
             m_frames++;
             if (m_frames >= move_period(int'(score))) begin mv = 1; m_frames = 0; end
           end
        default: if (start && m_hold) begin
             m_phase = 1; m_frames = 0; clr = 1; m_hold = 0;
           end else if (frame_tick && m_frames < HOLD_FRAMES) begin
             m_frames++;
             if (m_frames == HOLD_FRAMES) m_hold = 1;
           end
      endcase
    end
    exp_q.push_back({3'(m_phase), clr, mv, (m_phase == 2), m_hold});
  endtask

  task automatic compare();
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("state",      32'(state),      32'(e[6:4]));
      check("clear_game", 32'(clear_game), 32'(e[3]));
      check("move_tick",  32'(move_tick),  32'(e[2]));
      check("play_en",    32'(play_en),    32'(e[1]));
      check("hold_done",  32'(hold_done),  32'(e[0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic press_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_game(input bit go, input bit vic);
    game_over  = go;
    victory    = vic;
    frame_tick = 1'b1;
    tick();
    game_over  = 1'b0;
    victory    = 1'b0;
    frame_tick = 1'b0;
    tick();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // First game: clear pulse, 60-frame arm, first move 30 frames into PLAY.
    press_start();
    tick();
    run_frames(ARM_FRAMES);
    run_frames(BASE_PERIOD);

    // Steady rates: score 5 -> 20 frames, 15 and 12 -> clamped to 8.
    score = 4'd5;  run_frames(45);
    score = 4'd15; run_frames(20);
    score = 4'd12; run_frames(20);

    // Simultaneous game_over and victory on a frame: OVER wins, no move.
    end_game(1'b1, 1'b1);

    // Early start ignored, hold expires at frame 90, saturates, restart.
    run_frames(50);
    press_start();
    run_frames(HOLD_FRAMES - 50 + 5);
    press_start();
    tick();

    // Score jumps 0 -> 10 with 25 frames already counted.
    score = 4'd0;
    run_frames(ARM_FRAMES);
    run_frames(25);
    score = 4'd10;
    run_frames(22);

    // Victory path and restart from WIN.
    end_game(1'b0, 1'b1);
    run_frames(HOLD_FRAMES);
    press_start();

    // Reset arriving together with the frame that would complete a period.
    score = 4'd0;
    run_frames(ARM_FRAMES);
    run_frames(BASE_PERIOD - 1);
    reset      = 1'b1;
    frame_tick = 1'b1;
    tick();
    reset      = 1'b0;
    frame_tick = 1'b0;
    repeat (3) tick();
    run_frames(5);

    // Randomized traffic.
    for (int c = 0; c < 5000; c++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      start      = ($urandom_range(0, 15) == 0);
      game_over  = ($urandom_range(0, 199) == 0);
      victory    = ($urandom_range(0, 199) == 0);
      reset      = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 63) == 0) score = 4'($urandom_range(0, 15));
      tick();
    end
    frame_tick = 1'b0;
    start      = 1'b0;
    game_over  = 1'b0;
    victory    = 1'b0;
    reset      = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
